// File: rtl/dbus_arbiter.sv
// -----------------------------------------------------------------------------
// dbus_arbiter
//
// Shares one external data bus between the pipeline memory stage (port M) and
// a secondary master such as DMA or debug (port D). The block runs one bus
// cycle at a time, waits for the slave's DACK, arbitrates round-robin between
// the two ports, and aborts a bus cycle that waits too long for DACK.
//
// Handshakes:
//   M port : M_DAS is a level request. The port holds M_DAS and its qualifiers
//            stable while M_HLT is high. The cycle in which M_HLT drops while
//            M_DAS is high is the completion cycle, and M_DATAI is valid then.
//   D port : D_REQ is a level request. D_GNT pulses for one cycle when the
//            request is accepted. D_DONE (with D_ERR and D_RDATA) pulses one
//            cycle after the bus cycle completes. D_REQ must be low in the
//            D_DONE cycle, or the port is granted again.
//   Bus    : DAS/DRD/DWR/DADDR/DATAO/DLEN are driven for the whole bus cycle,
//            and are all zero between cycles. The slave ends the cycle with
//            DACK, and DATAI is valid with DACK. DACK is ignored between bus
//            cycles. At least one idle cycle separates two bus cycles.
//
// Ports:
//   CLK, RES                 clock; synchronous active-high reset
//   M_DAS/M_DRD/M_DWR        memory-stage request, load and store qualifiers
//   M_DADDR/M_DATAO/M_DLEN   memory-stage address, store data and size
//   M_DATAI, M_HLT           load data and pipeline stall
//   D_REQ/D_WE               secondary request and write enable
//   D_ADDR/D_WDATA/D_LEN     secondary address, write data and size
//   D_GNT/D_DONE/D_ERR       grant pulse, completion pulse, timeout flag
//   D_RDATA                  registered read data for the secondary master
//   DADDR/DATAO/DLEN         bus address, write data and size
//   DRD/DWR/DAS              bus read, write and address strobes
//   DATAI, DACK              bus read data and slave acknowledge
//   BUS_ERR                  one-cycle pulse on every timeout
//   o_dbg_state              current arbiter state (0 idle, 1 core, 2 dma)
// -----------------------------------------------------------------------------
module dbus_arbiter #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        M_DAS,
    input  logic        M_DRD,
    input  logic        M_DWR,
    input  logic [31:0] M_DADDR,
    input  logic [31:0] M_DATAO,
    input  logic [2:0]  M_DLEN,
    output logic [31:0] M_DATAI,
    output logic        M_HLT,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [2:0]  D_LEN,
    output logic        D_GNT,
    output logic        D_DONE,
    output logic        D_ERR,
    output logic [31:0] D_RDATA,
    output logic [31:0] DADDR,
    output logic [31:0] DATAO,
    output logic [2:0]  DLEN,
    output logic        DRD,
    output logic        DWR,
    output logic        DAS,
    input  logic [31:0] DATAI,
    input  logic        DACK,
    output logic        BUS_ERR,
    output logic [1:0]  o_dbg_state
);

    // The counter must reach TIMEOUT_CYC-1. With the timeout disabled it is
    // kept one bit wide so that the declarations stay legal.
    localparam int             WCW     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit             TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [WCW-1:0] WC_LAST = WCW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CORE = 2'd1,
        ST_DMA  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic           r_last_d;       // 1: the last completed bus cycle belonged to port D
    logic [WCW-1:0] r_wait_cnt;

    // Launch registers, loaded on the grant edge
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [2:0]     r_len;
    logic           r_rd;
    logic           r_wr;

    logic           r_d_done;
    logic           r_d_err;
    logic [31:0]    r_d_rdata;

    logic           w_busy;
    logic           w_ack_cmp;
    logic           w_to_cmp;
    logic           w_cmp;
    logic           w_m_win;
    logic           w_d_win;

    assign w_busy    = (r_state != ST_IDLE);
    assign w_ack_cmp = w_busy & DACK;
    // A timeout is the last allowed wait cycle that still has no DACK. A DACK
    // in that same cycle counts as a normal completion.
    assign w_to_cmp  = w_busy & ~DACK & TO_EN & (r_wait_cnt == WC_LAST);
    assign w_cmp     = w_ack_cmp | w_to_cmp;

    // Round-robin tie break: on contention the port that did not own the last
    // bus cycle wins. The two win terms can never both be true.
    assign w_m_win = M_DAS & (~D_REQ | r_last_d);
    assign w_d_win = D_REQ & (~M_DAS | ~r_last_d);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_m_win) begin
                    w_next_state = ST_CORE;
                end else if (w_d_win) begin
                    w_next_state = ST_DMA;
                end
            end
            ST_CORE, ST_DMA: begin
                if (w_cmp) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state    <= ST_IDLE;
            r_last_d   <= 1'b1;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_len      <= '0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_d_done   <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            r_state  <= w_next_state;
            r_d_done <= 1'b0;
            r_d_err  <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_m_win) begin
                    r_addr  <= M_DADDR;
                    r_wdata <= M_DATAO;
                    r_len   <= M_DLEN;
                    r_rd    <= M_DRD;
                    r_wr    <= M_DWR;
                end else if (w_d_win) begin
                    r_addr  <= D_ADDR;
                    r_wdata <= D_WDATA;
                    r_len   <= D_LEN;
                    r_rd    <= ~D_WE;
                    r_wr    <= D_WE;
                end
            end else if (w_cmp) begin
                r_last_d   <= (r_state == ST_DMA);
                r_wait_cnt <= '0;
                if (r_state == ST_DMA) begin
                    r_d_done  <= 1'b1;
                    r_d_err   <= w_to_cmp;
                    r_d_rdata <= w_to_cmp ? 32'hFFFF_FFFF : DATAI;
                end
            end else if (TO_EN) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    // Bus pins are all zero between bus cycles
    assign DAS   = w_busy;
    assign DADDR = w_busy ? r_addr  : 32'h0;
    assign DATAO = w_busy ? r_wdata : 32'h0;
    assign DLEN  = w_busy ? r_len   : 3'b000;
    assign DRD   = w_busy & r_rd;
    assign DWR   = w_busy & r_wr;

    // The stall drops in the completion cycle itself, so the memory stage
    // captures M_DATAI on the same edge that returns the arbiter to idle.
    assign M_HLT   = M_DAS & ~((r_state == ST_CORE) & w_cmp);
    assign M_DATAI = w_to_cmp ? 32'hFFFF_FFFF : DATAI;

    assign D_GNT   = ~RES & (r_state == ST_IDLE) & w_d_win;
    assign D_DONE  = r_d_done;
    assign D_ERR   = r_d_err;
    assign D_RDATA = r_d_rdata;
    assign BUS_ERR = ~RES & w_to_cmp;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dbus_arbiter.sv
module tb_dbus_arbiter;

  localparam int TO = 15;
  localparam logic [31:0] MA = 32'h0000_0100;
  localparam logic [31:0] MW = 32'h1111_1111;
  localparam logic [2:0]  ML = 3'b100;
  localparam logic [31:0] DA = 32'h0000_2000;
  localparam logic [31:0] DW = 32'h55AA_55AA;
  localparam logic [2:0]  DL = 3'b010;

  logic clk, res;
  logic m_das, m_drd, m_dwr;
  logic [31:0] m_daddr, m_datao, m_datai;
  logic [2:0] m_dlen;
  logic m_hlt;
  logic d_req, d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0] d_len;
  logic d_gnt, d_done, d_err;
  logic [31:0] daddr, datao, datai;
  logic [2:0] dlen;
  logic drd, dwr, das, dack, bus_err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  dbus_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .CLK(clk), .RES(res),
    .M_DAS(m_das), .M_DRD(m_drd), .M_DWR(m_dwr),
    .M_DADDR(m_daddr), .M_DATAO(m_datao), .M_DLEN(m_dlen),
    .M_DATAI(m_datai), .M_HLT(m_hlt),
    .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata), .D_LEN(d_len),
    .D_GNT(d_gnt), .D_DONE(d_done), .D_ERR(d_err), .D_RDATA(d_rdata),
    .DADDR(daddr), .DATAO(datao), .DLEN(dlen),
    .DRD(drd), .DWR(dwr), .DAS(das),
    .DATAI(datai), .DACK(dack), .BUS_ERR(bus_err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    res = 1'b0; m_das = 1'b0; m_drd = 1'b0; m_dwr = 1'b0;
    d_req = 1'b0; d_we = 1'b0; dack = 1'b0; datai = 32'h0;
    m_daddr = MA; m_datao = MW; m_dlen = ML;
    d_addr = DA; d_wdata = DW; d_len = DL;
  endtask

  task automatic do_reset();
    idle_inputs();
    res = 1'b1;
    step();
    res = 1'b0;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic        rst, m, d, ack;
    logic [31:0] di;
    logic        e_hlt, e_gnt, e_done;
    logic [1:0]  e_own;   // 0 bus idle, 1 M owns bus, 2 D owns bus
  } vec_t;

  function automatic vec_t mk(input logic rst, m, d, ack, input logic [31:0] di,
                              input logic hlt, gnt, done, input logic [1:0] own);
    vec_t v;
    v.rst = rst; v.m = m; v.d = d; v.ack = ack; v.di = di;
    v.e_hlt = hlt; v.e_gnt = gnt; v.e_done = done; v.e_own = own;
    return v;
  endfunction

  vec_t tbl[$];

  // ---------------- random phase: reference model + scoreboard ----------------
  localparam int TW = 69;
  logic [TW-1:0] exp_q[$];    // {addr, wdata, len, rd, wr} of granted bus cycles
  logic [32:0]   dexp_q[$];   // {err, rdata} of D completions

  int   mo_own;        // 0 none, 1 M, 2 D
  int   mo_cycles;     // bus cycles already spent in the current transfer
  bit   mo_last_d;
  bit   mo_done_next;
  logic prev_das;
  bit   m_act, d_pend, d_wait;

  task automatic model_reset();
    mo_own = 0; mo_cycles = 0; mo_last_d = 1'b1; mo_done_next = 1'b0;
    prev_das = 1'b0; m_act = 1'b0; d_pend = 1'b0; d_wait = 1'b0;
    exp_q.delete(); dexp_q.delete();
  endtask

  task automatic rand_cycle(input bit drain, input int ack_div);
    bit busy, ack_c, to_c, fin;
    logic [TW-1:0] t;
    logic [32:0]   r;
    int sz;
    // environment
    if (!drain && !m_act && $urandom_range(0, 1) == 1) begin
      m_act = 1'b1;
      m_daddr = $urandom; m_datao = $urandom;
      sz = $urandom_range(0, 2);
      m_dlen = (sz == 0) ? 3'b001 : (sz == 1) ? 3'b010 : 3'b100;
      m_drd = 1'($urandom_range(0, 1)); m_dwr = ~m_drd;
    end
    m_das = m_act;
    if (!drain && !d_pend && !d_wait && $urandom_range(0, 2) == 0) begin
      d_pend = 1'b1;
      d_addr = $urandom; d_wdata = $urandom;
      sz = $urandom_range(0, 2);
      d_len = (sz == 0) ? 3'b001 : (sz == 1) ? 3'b010 : 3'b100;
      d_we = 1'($urandom_range(0, 1));
    end
    d_req = d_pend;
    dack = drain ? 1'b1 : ($urandom_range(0, ack_div - 1) == 0);
    datai = $urandom;
    settle();

    // expectations from the arbitration rules
    busy  = (mo_own != 0);
    ack_c = busy && dack;
    to_c  = busy && !dack && (mo_cycles + 1 == TO);
    fin   = ack_c || to_c;
    chk("rnd_das", das, busy);
    chk("rnd_bus_err", bus_err, to_c);
    chk("rnd_hlt", m_hlt, m_das && !(mo_own == 1 && fin));
    chk("rnd_gnt", d_gnt, !busy && d_req && (!m_das || !mo_last_d));
    chk("rnd_done", d_done, mo_done_next);
    if (mo_own == 1 && fin) chk("rnd_m_datai", m_datai, to_c ? 32'hFFFF_FFFF : datai);

    if (das === 1'b1 && prev_das !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_txn", 64'd1, 64'd0);
      end else begin
        t = exp_q.pop_front();
        chk("sb_addr", daddr, t[68:37]);
        chk("sb_wdata", datao, t[36:5]);
        chk("sb_len_rd_wr", {dlen, drd, dwr}, t[4:0]);
      end
    end
    if (d_done === 1'b1) begin
      if (dexp_q.size() == 0) begin
        chk("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        r = dexp_q.pop_front();
        chk("sb_d_err_rdata", {d_err, d_rdata}, r);
      end
    end
    prev_das = das;

    // environment reacts to what it sees
    if (m_act && m_hlt === 1'b0) m_act = 1'b0;
    if (d_pend && d_gnt === 1'b1) begin d_pend = 1'b0; d_wait = 1'b1; end
    else if (d_wait && d_done === 1'b1) d_wait = 1'b0;

    // model advances over the clock edge
    mo_done_next = 1'b0;
    if (busy) begin
      if (fin) begin
        mo_last_d = (mo_own == 2);
        if (mo_own == 2) begin
          mo_done_next = 1'b1;
          dexp_q.push_back({to_c, to_c ? 32'hFFFF_FFFF : datai});
        end
        mo_own = 0; mo_cycles = 0;
      end else begin
        mo_cycles++;
      end
    end else if (m_das && (!d_req || mo_last_d)) begin
      mo_own = 1;
      exp_q.push_back({m_daddr, m_datao, m_dlen, m_drd, m_dwr});
    end else if (d_req) begin
      mo_own = 2;
      exp_q.push_back({d_addr, d_wdata, d_len, ~d_we, d_we});
    end
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t v;
    logic [31:0] exp_addr, exp_data;
    logic [2:0]  exp_len;

    idle_inputs();
    #1;
    res = 1'b1;
    step();
    step();
    // reset state, M_HLT follows M_DAS
    m_das = 1'b1;
    settle();
    chk("rst_das", das, 0);
    chk("rst_daddr", daddr, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_hlt", m_hlt, 1);
    idle_inputs();
    res = 1'b1;
    step();
    res = 1'b0;

    // rst  m  d ack datai          hlt gnt done own
    tbl.push_back(mk(1, 1, 0, 0, 32'h0,          1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,          1, 0, 0, 0)); // M load request
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,          1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 32'hDEADBEEF,   0, 0, 0, 1)); // DACK at N+2
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,          0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,          0, 0, 0, 0)); // last owner back to D
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,          1, 0, 0, 0)); // tie -> M
    tbl.push_back(mk(0, 1, 1, 1, 32'h0000_1234,  0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,          1, 1, 0, 0)); // tie -> D
    tbl.push_back(mk(0, 1, 1, 1, 32'hCAFE_0001,  1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,          1, 0, 1, 0)); // D_DONE, M granted
    tbl.push_back(mk(0, 1, 1, 1, 32'h0000_2222,  0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,          1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 32'hCAFE_0002,  1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,          1, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 32'h0000_3333,  0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,          0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 32'hCAFE_0003,  0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,          0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h7777_7777,  0, 0, 0, 0)); // spurious DACK
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,          0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      res = v.rst; m_das = v.m; m_drd = 1'b1; m_dwr = 1'b0;
      d_req = v.d; d_we = 1'b0; dack = v.ack; datai = v.di;
      settle();
      exp_addr = (v.e_own == 1) ? MA : (v.e_own == 2) ? DA : 32'h0;
      exp_data = (v.e_own == 1) ? MW : (v.e_own == 2) ? DW : 32'h0;
      exp_len  = (v.e_own == 1) ? ML : (v.e_own == 2) ? DL : 3'b000;
      chk($sformatf("tbl%0d_hlt", i), m_hlt, v.e_hlt);
      chk($sformatf("tbl%0d_gnt", i), d_gnt, v.e_gnt);
      chk($sformatf("tbl%0d_done", i), d_done, v.e_done);
      chk($sformatf("tbl%0d_das", i), das, v.e_own != 0);
      chk($sformatf("tbl%0d_daddr", i), daddr, exp_addr);
      chk($sformatf("tbl%0d_datao", i), datao, exp_data);
      chk($sformatf("tbl%0d_dlen", i), dlen, exp_len);
      chk($sformatf("tbl%0d_rdwr", i), {drd, dwr}, {v.e_own != 0, 1'b0});
      chk($sformatf("tbl%0d_m_datai", i), m_datai, v.di);
      chk($sformatf("tbl%0d_bus_err", i), bus_err, 0);
      if (v.e_done) chk($sformatf("tbl%0d_d_err", i), d_err, 0);
      step();
    end
    res = 1'b0;
    settle();
    chk("tbl_d_rdata", d_rdata, 32'hCAFE_0003);

    // timeout: M load, DACK never comes
    do_reset();
    m_das = 1'b1; m_drd = 1'b1; datai = 32'h0BAD_F00D;
    settle();
    chk("to_req_hlt", m_hlt, 1);
    step();
    for (int c = 1; c <= TO; c++) begin
      settle();
      if (c < TO) begin
        chk($sformatf("to_c%0d_bus_err", c), bus_err, 0);
        chk($sformatf("to_c%0d_hlt", c), m_hlt, 1);
      end else begin
        chk("to_last_bus_err", bus_err, 1);
        chk("to_last_hlt", m_hlt, 0);
        chk("to_last_m_datai", m_datai, 32'hFFFF_FFFF);
        chk("to_last_das", das, 1);
      end
      step();
    end
    m_das = 1'b0;
    settle();
    chk("to_after_das", das, 0);
    chk("to_after_bus_err", bus_err, 0);
    step();

    // D write, DACK on the third bus cycle, request dropped mid-transfer
    d_req = 1'b1; d_we = 1'b1; d_addr = DA; d_wdata = DW; d_len = DL;
    settle();
    chk("dw_gnt", d_gnt, 1);
    chk("dw_req_das", das, 0);
    step();
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) d_req = 1'b0;
      dack = (c == 3);
      settle();
      chk($sformatf("dw_c%0d_das", c), das, 1);
      chk($sformatf("dw_c%0d_rdwr", c), {drd, dwr}, 2'b01);
      chk($sformatf("dw_c%0d_datao", c), datao, DW);
      chk($sformatf("dw_c%0d_daddr", c), daddr, DA);
      chk($sformatf("dw_c%0d_dlen", c), dlen, DL);
      chk($sformatf("dw_c%0d_done", c), d_done, 0);
      step();
    end
    dack = 1'b0;
    settle();
    chk("dw_done", d_done, 1);
    chk("dw_err", d_err, 0);
    chk("dw_done_das", das, 0);
    step();
    settle();
    chk("dw_done_pulse", d_done, 0);

    // reset on the second DMA cycle
    d_req = 1'b1; d_we = 1'b0;
    settle();
    chk("rd_gnt", d_gnt, 1);
    step();
    settle();
    chk("rd_c1_das", das, 1);
    step();
    res = 1'b1;
    settle();
    step();
    res = 1'b0; d_req = 1'b0;
    settle();
    chk("rd_after_rst_strobes", {das, drd, dwr}, 3'b000);
    chk("rd_after_rst_done", d_done, 0);
    step();
    settle();
    chk("rd_after_rst_done2", d_done, 0);
    m_das = 1'b1; m_drd = 1'b1; d_req = 1'b1;
    settle();
    chk("rd_tie_gnt", d_gnt, 0);
    step();
    dack = 1'b1; d_req = 1'b0;
    settle();
    chk("rd_tie_das", das, 1);
    chk("rd_tie_daddr", daddr, MA);
    chk("rd_tie_hlt", m_hlt, 0);
    step();

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) rand_cycle(1'b0, 2);
    for (int n = 0; n < 1500; n++) rand_cycle(1'b0, 16);
    for (int n = 0; n < 20; n++) rand_cycle(1'b1, 1);
    chk("sb_txn_queue_empty", exp_q.size(), 0);
    chk("sb_done_queue_empty", dexp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
